master_tx_ltssm: RTL and testbench

//  Transmit-side LTSSM sequencer, counterpart of the master RX LTSSM. For each substate issued by the

---
 rtl/master_tx_ltssm.sv | 127 ++++++++++++
 tb/tb_master_tx_ltssm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/master_tx_ltssm.sv
// master_tx_ltssm: transmit-side LTSSM sequencer selecting ordered sets, electrical idle and receiver detection per substate
module master_tx_ltssm #(
    parameter int MAXLANES = 16,
    parameter int TS1_POLL = 1024,
    parameter int TS2_CNT  = 16,
    parameter int TS1_CFG  = 2,
    parameter int IDLE_CNT = 16,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          substate,
    input  logic                forceDetect,
    input  logic                osSent,
    input  logic                detectDone,
    input  logic [MAXLANES-1:0] detectResult,
    output logic                finish,
    output logic                sendOs,
    output logic [2:0]          osType,
    output logic                linkNumPad,
    output logic                laneNumPad,
    output logic                txElecIdle,
    output logic                detectReq,
    output logic                disableScrambler,
    output logic [4:0]          numberOfDetectedLanes
);
    typedef enum logic [1:0] {IDLE, DETECT, SEND, HOLD} state_t;

    state_t           state_q, state_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tgt;
    logic             pend_q, pend_d;
    logic             finish_q, finish_d;
    logic             send_q, send_d;
    logic [2:0]       os_q, os_d;
    logic             link_q, link_d;
    logic             lane_q, lane_d;
    logic             idle_q, idle_d;
    logic             req_q, req_d;
    logic             dis_q, dis_d;
    logic [4:0]       width_q, width_d;
    logic [3:0]       ld;
    logic             new_req, valid, hit;
    logic [7:0]       run_len;

    assign ld      = forceDetect ? 4'd0 : substate;
    assign new_req = forceDetect || substate != last_q;
    assign valid   = ld <= 4'd9;
    assign tgt     = last_q == 4'd2 ? CNT_W'(TS1_POLL) :
                     (last_q == 4'd3 || last_q == 4'd8) ? CNT_W'(TS2_CNT) :
                     last_q == 4'd9 ? CNT_W'(IDLE_CNT) : CNT_W'(TS1_CFG);
    assign hit     = state_q == SEND && osSent && cnt_q + CNT_W'(1) == tgt;

    // length of the run of present receivers starting at lane 0
    always_comb begin
        run_len = '0;
        for (int i = MAXLANES - 1; i >= 0; i--) run_len = detectResult[i] ? run_len + 8'd1 : 8'd0;
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_q   <= 4'hF;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            finish_q <= 1'b0;
            send_q   <= 1'b0;
            os_q     <= 3'd0;
            link_q   <= 1'b1;
            lane_q   <= 1'b1;
            idle_q   <= 1'b1;
            req_q    <= 1'b0;
            dis_q    <= 1'b0;
            width_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            finish_q <= finish_d;
            send_q   <= send_d;
            os_q     <= os_d;
            link_q   <= link_d;
            lane_q   <= lane_d;
            idle_q   <= idle_d;
            req_q    <= req_d;
            dis_q    <= dis_d;
            width_q  <= width_d;
        end
    end

    // a new request always reloads; otherwise detection or reaching the OS target parks in HOLD
    always_comb begin
        state_d = state_q;
        if (new_req) state_d = !valid ? IDLE : ld == 4'd0 ? HOLD : ld == 4'd1 ? DETECT : SEND;
        else if ((state_q == DETECT && detectDone) || hit) state_d = HOLD;
    end

    // outputs load from the substate table on a new request, pulses fire one cycle after their cause
    always_comb begin
        last_d   = new_req ? ld : last_q;
        cnt_d    = new_req ? '0 : (state_q == SEND && osSent && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        pend_d   = new_req && ld <= 4'd1;
        finish_d = !new_req && ((pend_q && state_q == HOLD) || (state_q == DETECT && detectDone) || hit);
        req_d    = !new_req && pend_q && state_q == DETECT;
        send_d   = new_req ? valid && ld >= 4'd2 : send_q;
        os_d     = !new_req ? os_q : (!valid || ld <= 4'd1) ? 3'd0 : ld == 4'd9 ? 3'd3 :
                   (ld == 4'd3 || ld == 4'd8) ? 3'd2 : 3'd1;
        link_d   = new_req ? !valid || ld <= 4'd3 : link_q;
        lane_d   = new_req ? !valid || ld <= 4'd5 : lane_q;
        idle_d   = new_req ? !valid || ld <= 4'd1 : idle_q;
        dis_d    = new_req ? valid && ld != 4'd9 : dis_q;
        width_d  = !detectDone ? width_q : run_len >= 8'd16 ? 5'd16 : run_len >= 8'd8 ? 5'd8 :
                   run_len >= 8'd4 ? 5'd4 : run_len >= 8'd2 ? 5'd2 : run_len >= 8'd1 ? 5'd1 : 5'd0;
    end

    assign finish                = finish_q;
    assign sendOs                = send_q;
    assign osType                = os_q;
    assign linkNumPad            = link_q;
    assign laneNumPad            = lane_q;
    assign txElecIdle            = idle_q;
    assign detectReq             = req_q;
    assign disableScrambler      = dis_q;
    assign numberOfDetectedLanes = width_q;
endmodule

// File: tb/tb_master_tx_ltssm.sv
// tb_master_tx_ltssm: directed bench for master_tx_ltssm with a per-cycle reference model
module tb_master_tx_ltssm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  substate = 4'd0;
    logic        forceDetect = 1'b0;
    logic        osSent = 1'b0;
    logic        detectDone = 1'b0;
    logic [15:0] detectResult = 16'h0;
    logic        finish, sendOs, linkNumPad, laneNumPad, txElecIdle, detectReq, disableScrambler;
    logic [2:0]  osType;
    logic [4:0]  numberOfDetectedLanes;

    int n_chk = 0;
    int n_fail = 0;

    int m_last, m_cnt, m_age, m_width;
    bit m_done, e_fin, e_req;

    always #5 clk = ~clk;

    master_tx_ltssm dut (
        .clk(clk), .reset(reset), .substate(substate), .forceDetect(forceDetect),
        .osSent(osSent), .detectDone(detectDone), .detectResult(detectResult),
        .finish(finish), .sendOs(sendOs), .osType(osType), .linkNumPad(linkNumPad),
        .laneNumPad(laneNumPad), .txElecIdle(txElecIdle), .detectReq(detectReq),
        .disableScrambler(disableScrambler), .numberOfDetectedLanes(numberOfDetectedLanes)
    );

    function automatic int need(int s);
        return s == 2 ? 1024 : (s == 3 || s == 8 || s == 9) ? 16 : 2;
    endfunction

    function automatic int lanes(logic [15:0] r);
        int n = 0;
        while (n < 16 && r[n]) n++;
        for (int p = 16; p >= 1; p = p / 2) if (n >= p) return p;
        return 0;
    endfunction

    function automatic logic [14:0] expect_vec();
        int s = m_last;
        logic [2:0] os;
        logic so, lk, ln, ei, ds;
        logic [4:0] w = m_width[4:0];
        if (s > 9) begin
            os = 3'd0; so = 1'b0; lk = 1'b1; ln = 1'b1; ei = 1'b1; ds = 1'b0;
        end else begin
            so = s >= 2; ei = s < 2; ds = s != 9; lk = s < 4; ln = s < 6;
            os = s < 2 ? 3'd0 : s == 9 ? 3'd3 : (s == 3 || s == 8) ? 3'd2 : 3'd1;
        end
        return {e_fin, so, os, lk, ln, ei, e_req, ds, w};
    endfunction

    task automatic model_reset();
        m_last = 15; m_cnt = 0; m_age = 0; m_done = 0; m_width = 0; e_fin = 0; e_req = 0;
    endtask

    task automatic model_step();
        int ld;
        bit nr;
        if (!reset) return;
        ld = forceDetect ? 0 : int'(substate);
        nr = forceDetect || int'(substate) != m_last;
        e_fin = 0;
        e_req = 0;
        if (detectDone) m_width = lanes(detectResult);
        if (nr) begin
            m_last = ld; m_cnt = 0; m_age = 0; m_done = 0;
        end else begin
            m_age++;
            if (m_age == 1 && m_last == 0) e_fin = 1;
            if (m_age == 1 && m_last == 1) e_req = 1;
            if (m_last == 1 && !m_done && detectDone) begin
                e_fin = 1; m_done = 1;
            end
            if (m_last >= 2 && m_last <= 9 && !m_done && osSent) begin
                m_cnt++;
                if (m_cnt == need(m_last)) begin
                    e_fin = 1; m_done = 1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [14:0] act = {finish, sendOs, osType, linkNumPad, laneNumPad, txElecIdle, detectReq,
                            disableScrambler, numberOfDetectedLanes};
        logic [14:0] exp = expect_vec();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got %b want %b (fin,send,os,lk,ln,ei,req,dis,w)", $time, act, exp);
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic pulses(int n);
        repeat (n) begin
            osSent = 1'b1; tick(); osSent = 1'b0; tick();
        end
    endtask

    task automatic go(int s);
        substate = s[3:0];
        tick();
    endtask

    task automatic detect_width(logic [15:0] r, int w);
        go(0); go(1); tick();
        detectResult = r; detectDone = 1'b1; tick(); detectDone = 1'b0;
        chk("width", int'(numberOfDetectedLanes), w);
        tick();
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_elec", int'(txElecIdle), 1);
        chk("rst_pads", int'({linkNumPad, laneNumPad}), 3);
        chk("rst_os", int'(osType), 0);
        chk("rst_send", int'(sendOs), 0);
        reset = 1'b1;
        tick();
        tick(); chk("quiet_fin", int'(finish), 1);
        tick(); chk("quiet_fin_once", int'(finish), 0);

        go(2); chk("poll_os", int'(osType), 1);
        pulses(1023); chk("poll_1023", int'(finish), 0);
        osSent = 1'b1; tick(); osSent = 1'b0; chk("poll_1024", int'(finish), 1);
        tick(); chk("poll_after", int'(finish), 0);

        go(1); tick(); chk("det_req", int'(detectReq), 1);
        tick(); chk("det_req_once", int'(detectReq), 0);
        detectResult = 16'h00FF; detectDone = 1'b1; tick(); detectDone = 1'b0;
        chk("w_00ff", int'(numberOfDetectedLanes), 8);
        chk("det_fin", int'(finish), 1);
        chk("det_elec", int'(txElecIdle), 1);
        tick();
        detect_width(16'hFFFB, 2);
        detect_width(16'hFFFE, 0);
        detect_width(16'h0007, 2);
        detect_width(16'hFFFF, 16);
        detect_width(16'h000F, 4);
        detect_width(16'h0001, 1);

        go(6); pulses(1);
        osSent = 1'b1; tick(); osSent = 1'b0; chk("cfg_fin", int'(finish), 1);
        tick();
        repeat (5) begin
            osSent = 1'b1; tick(); osSent = 1'b0; tick(); chk("cfg_nofin", int'(finish), 0);
        end
        chk("cfg_send", int'(sendOs), 1);
        chk("cfg_os", int'(osType), 1);
        chk("cfg_pads", int'({linkNumPad, laneNumPad}), 0);

        go(8); pulses(7);
        forceDetect = 1'b1; tick(); forceDetect = 1'b0; substate = 4'd0;
        chk("fd_os", int'(osType), 0);
        chk("fd_elec", int'(txElecIdle), 1);
        tick(); chk("fd_fin", int'(finish), 1);

        go(12); chk("unk_send", int'(sendOs), 0); chk("unk_elec", int'(txElecIdle), 1);
        tick(); tick(); chk("unk_fin", int'(finish), 0);

        substate = 4'd3; osSent = 1'b1; tick(); osSent = 1'b0;
        pulses(15); chk("ts2_15", int'(finish), 0);
        osSent = 1'b1; tick(); osSent = 1'b0; chk("ts2_fin", int'(finish), 1);
        tick();

        go(9); pulses(5);
        #2 reset = 1'b0;
        model_reset();
        #1 chk("mid_rst_send", int'(sendOs), 0);
        chk("mid_rst_os", int'(osType), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rl_os", int'(osType), 3);
        chk("rl_dis", int'(disableScrambler), 0);
        pulses(15);
        osSent = 1'b1; tick(); osSent = 1'b0; chk("idle_fin", int'(finish), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
